prefetch_queue: RTL and testbench

//  Parametrised circular byte queue between instruction fetch and prime_decoder.

---
 rtl/prefetch_queue.sv | 88 ++++++++
 tb/tb_prefetch_queue.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prefetch_queue.sv
// Circular byte queue between fetch and decode with a PEEK_N-byte peek window and variable-length pop.
// Latency: a push or pop is visible on peek_data/count one cycle after acceptance; peek_data is combinational from storage.
// Backpressure: push_ready = !full from registered count only; an oversize pop is rejected and flagged on pop_err next cycle.
module prefetch_queue #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4,
  parameter int PEEK_N = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push_valid,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     push_ready,
  input  logic                     pop_en,
  input  logic [1:0]               pop_len,
  output logic                     pop_err,
  output logic [PEEK_N*DATA_W-1:0] peek_data,
  output logic [1:0]               peek_avail,
  output logic [PTR_W:0]           count,
  output logic                     empty,
  output logic                     full
);

  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              pop_err_q;

  logic              push_acc;
  logic              pop_req;
  logic              pop_ok;
  logic              pop_rej;
  logic [CNT_W-1:0]  pop_amt;

  // Occupancy flags come from the counter so full and empty stay distinct when pointers are equal.
  assign full       = (count_q == CNT_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign count      = count_q;
  assign pop_err    = pop_err_q;
  assign peek_avail = (count_q >= CNT_W'(PEEK_N)) ? 2'(PEEK_N) : count_q[1:0];

  // A flush cancels any pop in the same cycle, so it neither retires bytes nor raises pop_err.
  assign push_acc = push_valid & push_ready;
  assign pop_req  = pop_en & (pop_len != 2'd0) & !flush;
  assign pop_ok   = pop_req & (pop_len <= peek_avail);
  assign pop_rej  = pop_req & (pop_len > peek_avail);
  assign pop_amt  = pop_ok ? CNT_W'(pop_len) : '0;

  // Storage write; no reset needed because lanes at or beyond count are masked on read.
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= push_data;
  end

  // Pointers, occupancy and the one-cycle reject pulse; flush re-bases rd_ptr onto the write point.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count_q   <= '0;
      pop_err_q <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + PTR_W'(push_acc);
      pop_err_q <= pop_rej;
      if (flush) begin
        rd_ptr  <= wr_ptr;
        count_q <= CNT_W'(push_acc);
      end else begin
        rd_ptr  <= rd_ptr + PTR_W'(pop_amt);
        count_q <= count_q + CNT_W'(push_acc) - pop_amt;
      end
    end
  end

  // Peek window: lane i shows the entry i places behind the head, wrapping, or zero when not occupied.
  always_comb begin
    peek_data = '0;
    for (int i = 0; i < PEEK_N; i++) begin
      if (CNT_W'(i) < count_q) peek_data[i*DATA_W +: DATA_W] = mem[rd_ptr + PTR_W'(i)];
    end
  end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        push_valid;
  logic [7:0]  push_data;
  logic        push_ready;
  logic        pop_en;
  logic [1:0]  pop_len;
  logic        pop_err;
  logic [23:0] peek_data;
  logic [1:0]  peek_avail;
  logic [4:0]  count;
  logic        empty;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the queue contents in order, head at index 0.
  logic [7:0] mq[$];
  bit         exp_err;

  prefetch_queue #(.DATA_W(8), .DEPTH(16), .PTR_W(4), .PEEK_N(3)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_en(pop_en), .pop_len(pop_len), .pop_err(pop_err),
    .peek_data(peek_data), .peek_avail(peek_avail), .count(count),
    .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [23:0] ep;
    int          sz;
    sz = mq.size();
    ep = '0;
    for (int i = 0; i < 3; i++) if (i < sz) ep[i*8 +: 8] = mq[i];
    chk({tag, ".count"},      32'(count),      32'(sz));
    chk({tag, ".empty"},      32'(empty),      32'(sz == 0));
    chk({tag, ".full"},       32'(full),       32'(sz == 16));
    chk({tag, ".push_ready"}, 32'(push_ready), 32'(sz != 16));
    chk({tag, ".peek_avail"}, 32'(peek_avail), 32'((sz < 3) ? sz : 3));
    chk({tag, ".peek_data"},  32'(peek_data),  32'(ep));
    chk({tag, ".pop_err"},    32'(pop_err),    32'(exp_err));
  endtask

  // One clock with the given inputs; the model applies the queue rules, then everything is compared.
  task automatic step(input bit pv, input logic [7:0] pd, input bit pe,
                      input logic [1:0] pl, input bit fl, input string tag);
    int  sz;
    int  avail;
    bit  push_ok;
    bit  pop_ok;
    bit  pop_rej;
    push_valid = pv; push_data = pd; pop_en = pe; pop_len = pl; flush = fl;
    sz      = mq.size();
    avail   = (sz < 3) ? sz : 3;
    push_ok = pv && (sz < 16);
    pop_ok  = pe && (pl != 0) && (int'(pl) <= avail) && !fl;
    pop_rej = pe && (pl != 0) && (int'(pl) > avail) && !fl;
    @(posedge clk);
    #1;
    if (fl) mq.delete();
    else if (pop_ok) for (int k = 0; k < int'(pl); k++) void'(mq.pop_front());
    if (push_ok) mq.push_back(pd);
    exp_err = pop_rej;
    push_valid = 1'b0; pop_en = 1'b0; pop_len = 2'd0; flush = 1'b0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    mq.delete();
    exp_err = 1'b0;
    #2;
    check_all("rst_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = 8'h00;
    pop_en = 1'b0; pop_len = 2'd0;
    exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_all("init");

    // T1: reset mid-operation with a push pending
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 2'd0, 1'b0, "t1_fill");
    push_valid = 1'b1; push_data = 8'h77;
    reset = 1'b1;
    mq.delete();
    exp_err = 1'b0;
    #2;
    check_all("t1_async");
    @(posedge clk);
    #1;
    check_all("t1_held");
    reset = 1'b0; push_valid = 1'b0;
    chk("t1_peek_zero", 32'(peek_data), 32'h0);

    // T2: fill to 16, 17th push ignored, then pop 3
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 2'd0, 1'b0, "t2_fill");
    chk("t2_full", 32'(full), 32'h1);
    step(1'b1, 8'hFF, 1'b0, 2'd0, 1'b0, "t2_push17");
    chk("t2_count16", 32'(count), 32'd16);
    step(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, "t2_pop3");
    chk("t2_peek", 32'(peek_data), 32'h050403);
    chk("t2_count13", 32'(count), 32'd13);

    // T3: wrap across the 15->0 boundary
    do_reset();
    for (int i = 0; i < 14; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 2'd0, 1'b0, "t3_fill");
    for (int i = 0; i < 4; i++)  step(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, "t3_pop");
    for (int i = 0; i < 8; i++)  step(1'b1, 8'(8'h20 + i), 1'b0, 2'd0, 1'b0, "t3_wrap");
    chk("t3_count10", 32'(count), 32'd10);
    chk("t3_peek_a", 32'(peek_data), 32'h201D1C);
    step(1'b0, 8'h00, 1'b1, 2'd2, 1'b0, "t3_pop2");
    step(1'b0, 8'h00, 1'b1, 2'd1, 1'b0, "t3_pop1");
    chk("t3_peek_wrap", 32'(peek_data), 32'h232221);

    // T4: simultaneous push and pop at count 5
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 2'd0, 1'b0, "t4_fill");
    step(1'b1, 8'hA9, 1'b1, 2'd2, 1'b0, "t4_both");
    chk("t4_count4", 32'(count), 32'd4);
    step(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, "t4_drain");
    chk("t4_last", 32'(peek_data), 32'h0000A9);

    // T5: underflow at count 1, pop_err pulses for exactly one cycle
    step(1'b0, 8'h00, 1'b1, 2'd3, 1'b0, "t5_under");
    chk("t5_err", 32'(pop_err), 32'h1);
    chk("t5_avail", 32'(peek_avail), 32'd1);
    step(1'b0, 8'h00, 1'b0, 2'd0, 1'b0, "t5_idle");
    chk("t5_err_clr", 32'(pop_err), 32'h0);

    // T6: flush with push and pop at count 9
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 2'd0, 1'b0, "t6_fill");
    chk("t6_count9", 32'(count), 32'd9);
    step(1'b1, 8'h4C, 1'b1, 2'd1, 1'b1, "t6_flush");
    chk("t6_peek", 32'(peek_data), 32'h00004C);
    chk("t6_err", 32'(pop_err), 32'h0);

    // Flush while full: push is gated by full
    for (int i = 0; i < 15; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 2'd0, 1'b0, "tf_fill");
    step(1'b1, 8'h99, 1'b0, 2'd0, 1'b1, "tf_flush_full");
    chk("tf_empty", 32'(empty), 32'h1);

    // Randomized traffic, alternating push-heavy and pop-heavy phases
    for (int n = 0; n < 1200; n++) begin
      bit         pv;
      bit         pe;
      bit         fl;
      logic [1:0] pl;
      if (((n / 100) % 2) == 0) begin
        pv = ($urandom_range(0, 9) < 8);
        pe = ($urandom_range(0, 9) < 3);
      end else begin
        pv = ($urandom_range(0, 9) < 3);
        pe = ($urandom_range(0, 9) < 8);
      end
      pl = 2'($urandom_range(0, 3));
      fl = ($urandom_range(0, 49) == 0);
      step(pv, 8'($urandom), pe, pl, fl, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
